// File: rtl/arrow_game_engine.sv
// Arrow game engine: scrolling arrow queue, beat-synchronous button judgement,
// score and combo counters. Feeds the 7-segment display block directly.
module arrow_game_engine #(
    parameter int unsigned STATE_BITS  = 1,
    parameter int unsigned RANDOM_BITS = 6,
    parameter int unsigned SCORE_MAX   = 9999,
    parameter int unsigned ARROW_NONE  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  metronome_clk,
    input  logic [STATE_BITS:0]   state,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_right,
    output logic [4:0]            cur_arrow0,
    output logic [4:0]            cur_arrow1,
    output logic [4:0]            cur_arrow2,
    output logic [4:0]            cur_arrow3,
    output logic [13:0]           score,
    output logic [13:0]           combo_count,
    output logic                  hit_pulse,
    output logic                  miss_pulse
);

    localparam logic [STATE_BITS:0] StGame  = (STATE_BITS + 1)'(0);
    localparam logic [STATE_BITS:0] StReset = (STATE_BITS + 1)'(2);

    localparam logic [4:0]  ArrowNone  = 5'(ARROW_NONE);
    localparam logic [4:0]  ArrowFirst = 5'd10;
    localparam logic [13:0] ScoreMax   = 14'(SCORE_MAX);

    localparam logic [RANDOM_BITS-1:0] LfsrSeed = RANDOM_BITS'(1);

    // Button bit order is {up, down, left, right} throughout.
    function automatic logic [3:0] required_mask(input logic [4:0] code);
        logic [3:0] m;
        case (code)
            5'd10:   m = 4'b1000;
            5'd11:   m = 4'b0100;
            5'd12:   m = 4'b0010;
            5'd13:   m = 4'b0001;
            5'd14:   m = 4'b1100;
            5'd15:   m = 4'b1010;
            5'd16:   m = 4'b1001;
            5'd17:   m = 4'b0110;
            5'd18:   m = 4'b0101;
            5'd19:   m = 4'b0011;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // State registers
    logic [2:0]             sync_q,     sync_d;
    logic [3:0]             btn_prev_q, btn_prev_d;
    logic [3:0]             mask_q,     mask_d;
    logic [RANDOM_BITS-1:0] lfsr_q,     lfsr_d;
    logic [4:0]             arrow0_q,   arrow0_d;
    logic [4:0]             arrow1_q,   arrow1_d;
    logic [4:0]             arrow2_q,   arrow2_d;
    logic [4:0]             arrow3_q,   arrow3_d;
    logic [13:0]            score_q,    score_d;
    logic [13:0]            combo_q,    combo_d;
    logic                   hit_q,      hit_d;
    logic                   miss_q,     miss_d;

    logic                   clear;
    logic                   in_game;
    logic                   beat;
    logic [3:0]             btn_lvl;
    logic [3:0]             btn_edge;
    logic [3:0]             front_req;
    logic                   front_empty;
    logic [RANDOM_BITS-1:0] lfsr_mod;
    logic [4:0]             new_arrow;

    // RESET state behaves exactly like the rst pin, including the sync chain.
    assign clear   = rst || (state == StReset);
    assign in_game = (state == StGame);

    assign beat     = sync_q[1] & ~sync_q[2];
    assign btn_lvl  = {btn_up, btn_down, btn_left, btn_right};
    assign btn_edge = btn_lvl & ~btn_prev_q;

    assign front_req   = required_mask(arrow3_q);
    assign front_empty = (arrow3_q == ArrowNone);

    assign lfsr_mod  = lfsr_q % RANDOM_BITS'(11);
    assign new_arrow = ArrowFirst + 5'(lfsr_mod);

    // Next-state: beat judgement, queue shift, mask accumulation, counters.
    always_comb begin
        sync_d     = {sync_q[1:0], metronome_clk};
        // Previous button levels track in every state, so a press held across
        // a pause is not re-detected as a fresh edge on resume.
        btn_prev_d = btn_lvl;
        mask_d     = mask_q;
        lfsr_d     = lfsr_q;
        arrow0_d   = arrow0_q;
        arrow1_d   = arrow1_q;
        arrow2_d   = arrow2_q;
        arrow3_d   = arrow3_q;
        score_d    = score_q;
        combo_d    = combo_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;

        if (in_game) begin
            if (beat) begin
                // Judge the window that just closed; this cycle's edges open the next one.
                if (!front_empty) begin
                    if (mask_q == front_req) begin
                        hit_d   = 1'b1;
                        score_d = (score_q < ScoreMax) ? score_q + 14'd1 : score_q;
                        combo_d = (combo_q < ScoreMax) ? combo_q + 14'd1 : combo_q;
                    end else begin
                        miss_d  = 1'b1;
                        combo_d = '0;
                    end
                end else if (mask_q != 4'b0000) begin
                    miss_d  = 1'b1;
                    combo_d = '0;
                end

                arrow3_d = arrow2_q;
                arrow2_d = arrow1_q;
                arrow1_d = arrow0_q;
                arrow0_d = new_arrow;
                lfsr_d   = {lfsr_q[RANDOM_BITS-2:0],
                            lfsr_q[RANDOM_BITS-1] ^ lfsr_q[RANDOM_BITS-2]};
                mask_d   = btn_edge;
            end else begin
                mask_d = mask_q | btn_edge;
            end
        end
    end

    // Register update with synchronous clear from rst or the RESET state.
    always_ff @(posedge clk) begin
        if (clear) begin
            sync_q     <= '0;
            btn_prev_q <= '0;
            mask_q     <= '0;
            lfsr_q     <= LfsrSeed;
            arrow0_q   <= ArrowNone;
            arrow1_q   <= ArrowNone;
            arrow2_q   <= ArrowNone;
            arrow3_q   <= ArrowNone;
            score_q    <= '0;
            combo_q    <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            btn_prev_q <= btn_prev_d;
            mask_q     <= mask_d;
            lfsr_q     <= lfsr_d;
            arrow0_q   <= arrow0_d;
            arrow1_q   <= arrow1_d;
            arrow2_q   <= arrow2_d;
            arrow3_q   <= arrow3_d;
            score_q    <= score_d;
            combo_q    <= combo_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    assign cur_arrow0  = arrow0_q;
    assign cur_arrow1  = arrow1_q;
    assign cur_arrow2  = arrow2_q;
    assign cur_arrow3  = arrow3_q;
    assign score       = score_q;
    assign combo_count = combo_q;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;

endmodule

// File: tb/tb_arrow_game_engine.sv
// Directed bench for arrow_game_engine with a scoreboard of expected
// per-beat results (SCORE_MAX reduced to 3 to reach saturation quickly).
`timescale 1ns/1ps
module tb_arrow_game_engine;

    localparam int unsigned ScoreMax = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        metronome_clk;
    logic [1:0]  state;
    logic        btn_up, btn_down, btn_left, btn_right;
    logic [4:0]  cur_arrow0, cur_arrow1, cur_arrow2, cur_arrow3;
    logic [13:0] score, combo_count;
    logic        hit_pulse, miss_pulse;

    always #5 clk = ~clk;

    arrow_game_engine #(
        .STATE_BITS (1),
        .RANDOM_BITS(6),
        .SCORE_MAX  (ScoreMax),
        .ARROW_NONE (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .metronome_clk(metronome_clk),
        .state        (state),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .cur_arrow0   (cur_arrow0),
        .cur_arrow1   (cur_arrow1),
        .cur_arrow2   (cur_arrow2),
        .cur_arrow3   (cur_arrow3),
        .score        (score),
        .combo_count  (combo_count),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse)
    );

    typedef struct {
        logic        hit;
        logic        miss;
        logic [4:0]  a0, a1, a2, a3;
        logic [13:0] score;
        logic [13:0] combo;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [5:0] m_lfsr;
    logic [4:0] m_a[4];
    int         m_score;
    int         m_combo;
    logic [3:0] m_mask;
    logic [1:0] m_state;

    function automatic logic [3:0] req_of(input logic [4:0] code);
        case (code)
            5'd10: return 4'b1000;
            5'd11: return 4'b0100;
            5'd12: return 4'b0010;
            5'd13: return 4'b0001;
            5'd14: return 4'b1100;
            5'd15: return 4'b1010;
            5'd16: return 4'b1001;
            5'd17: return 4'b0110;
            5'd18: return 4'b0101;
            5'd19: return 4'b0011;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_lfsr  = 6'b000001;
        for (int i = 0; i < 4; i++) m_a[i] = 5'd20;
        m_score = 0;
        m_combo = 0;
        m_mask  = 4'b0000;
    endtask

    task automatic set_state(input logic [1:0] s);
        state   = s;
        m_state = s;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_a0"},    32'(cur_arrow0), 32'd20);
        check({tag, "_a1"},    32'(cur_arrow1), 32'd20);
        check({tag, "_a2"},    32'(cur_arrow2), 32'd20);
        check({tag, "_a3"},    32'(cur_arrow3), 32'd20);
        check({tag, "_score"}, 32'(score),       32'd0);
        check({tag, "_combo"}, 32'(combo_count), 32'd0);
        check({tag, "_hit"},   32'(hit_pulse),   32'd0);
        check({tag, "_miss"},  32'(miss_pulse),  32'd0);
    endtask

    // One-cycle press of the buttons in m ({up,down,left,right}).
    task automatic press(input logic [3:0] m);
        {btn_up, btn_down, btn_left, btn_right} = m;
        @(posedge clk); #1;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        @(posedge clk); #1;
        if (m_state == 2'd0) m_mask = m_mask | m;
    endtask

    // One metronome period; co is pressed in the exact beat cycle.
    task automatic beat(input string tag, input logic [3:0] co);
        exp_t e;
        logic [3:0] r;
        e.hit  = 1'b0;
        e.miss = 1'b0;
        if (m_state == 2'd0) begin
            r = req_of(m_a[3]);
            if (m_a[3] != 5'd20) begin
                if (m_mask == r) begin
                    e.hit = 1'b1;
                    if (m_score < ScoreMax) m_score++;
                    if (m_combo < ScoreMax) m_combo++;
                end else begin
                    e.miss  = 1'b1;
                    m_combo = 0;
                end
            end else if (m_mask != 4'b0000) begin
                e.miss  = 1'b1;
                m_combo = 0;
            end
            m_a[3] = m_a[2];
            m_a[2] = m_a[1];
            m_a[1] = m_a[0];
            m_a[0] = 5'(10 + (m_lfsr % 11));
            m_lfsr = {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4]};
            m_mask = co;
        end
        e.a0    = m_a[0];
        e.a1    = m_a[1];
        e.a2    = m_a[2];
        e.a3    = m_a[3];
        e.score = 14'(m_score);
        e.combo = 14'(m_combo);
        sb.push_back(e);

        metronome_clk = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        // Now inside the beat cycle.
        {btn_up, btn_down, btn_left, btn_right} = co;
        @(posedge clk); #1;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;

        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard, expected an entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_hit"},   32'(hit_pulse),   32'(e.hit));
            check({tag, "_miss"},  32'(miss_pulse),  32'(e.miss));
            check({tag, "_a0"},    32'(cur_arrow0),  32'(e.a0));
            check({tag, "_a1"},    32'(cur_arrow1),  32'(e.a1));
            check({tag, "_a2"},    32'(cur_arrow2),  32'(e.a2));
            check({tag, "_a3"},    32'(cur_arrow3),  32'(e.a3));
            check({tag, "_score"}, 32'(score),       32'(e.score));
            check({tag, "_combo"}, 32'(combo_count), 32'(e.combo));
        end

        @(posedge clk); #1;
        check({tag, "_hit_end"},  32'(hit_pulse),  32'd0);
        check({tag, "_miss_end"}, 32'(miss_pulse), 32'd0);

        metronome_clk = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst           = 1'b1;
        metronome_clk = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        set_state(2'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_values("rst");

        // Idle beats fill the queue from the LFSR.
        for (int i = 0; i < 4; i++) beat($sformatf("idle%0d", i), 4'b0000);
        check("plan_a3", 32'(cur_arrow3), 32'd11);
        check("plan_a2", 32'(cur_arrow2), 32'd12);
        check("plan_a1", 32'(cur_arrow1), 32'd14);
        check("plan_a0", 32'(cur_arrow0), 32'd18);

        // Front arrow 11 needs down.
        press(4'b0100);
        beat("hit5", 4'b0000);
        check("plan5_score", 32'(score),       32'd1);
        check("plan5_combo", 32'(combo_count), 32'd1);
        check("plan5_a0",    32'(cur_arrow0),  32'd15);

        // Front arrow 12 needs left; right is wrong.
        press(4'b0001);
        beat("miss6", 4'b0000);
        check("plan6_score", 32'(score),       32'd1);
        check("plan6_combo", 32'(combo_count), 32'd0);
        check("plan6_a0",    32'(cur_arrow0),  32'd10);

        // Front arrow 14 needs up+down, pressed before pausing; pause presses ignored.
        press(4'b1100);
        set_state(2'd1);
        beat("pause1", 4'b0000);
        press(4'b0010);
        beat("pause2", 4'b0001);
        set_state(2'd0);
        beat("resume", 4'b0000);
        check("resume_score", 32'(score), 32'd2);

        // Front arrow 18 needs down+right; down lands in the beat cycle.
        press(4'b0001);
        beat("coincident", 4'b0100);
        // Down carried over: up+left plus down cannot match 15 (up+left).
        press(4'b1010);
        beat("next_window", 4'b0000);
        check("carry_combo", 32'(combo_count), 32'd0);

        // Consecutive hits drive score and combo into saturation.
        for (int i = 0; i < 5; i++) begin
            press(req_of(m_a[3]));
            beat($sformatf("sat%0d", i), 4'b0000);
        end
        check("sat_score", 32'(score),       32'(ScoreMax));
        check("sat_combo", 32'(combo_count), 32'(ScoreMax));

        // Half-built window discarded by RESET.
        press(4'b1000);
        set_state(2'd2);
        @(posedge clk); #1;
        set_state(2'd0);
        model_reset();
        check_reset_values("state_reset");
        beat("post_reset", 4'b0000);
        check("post_reset_a0", 32'(cur_arrow0), 32'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion, expected end of sequence");
        $fatal(1, "time limit reached");
    end

endmodule
